// File: rtl/round_scoreboard_if.sv
// Event inputs and game-state outputs of the round scoreboard.
interface round_scoreboard_if #(
  parameter int BIRDS_PER_ROUND = 10,
  parameter int NUM_ROUNDS      = 16,
  parameter int SCORE_W         = 14
);
  localparam int CNT_W = $clog2(BIRDS_PER_ROUND + 1);
  localparam int RND_W = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;

  logic                       restart;
  logic                       hit;
  logic                       escape;
  logic [BIRDS_PER_ROUND-1:0] bird_map;
  logic [CNT_W-1:0]           hit_count;
  logic [CNT_W-1:0]           esc_count;
  logic [RND_W-1:0]           round;
  logic [SCORE_W-1:0]         score;
  logic [15:0]                score_bcd;
  logic                       bcd_valid;
  logic                       round_done;
  logic                       game_over;
  logic                       game_won;

  modport master (
    output restart, hit, escape,
    input  bird_map, hit_count, esc_count, round, score, score_bcd,
           bcd_valid, round_done, game_over, game_won
  );

  modport slave (
    input  restart, hit, escape,
    output bird_map, hit_count, esc_count, round, score, score_bcd,
           bcd_valid, round_done, game_over, game_won
  );
endinterface

// File: rtl/round_scoreboard.sv
// Round/score bookkeeping for the shooting game, with sequential BCD display conversion.
//
//   state | meaning
//   PLAY  | hit/escape events accepted
//   EVAL  | one cycle: round judged, events dropped
//   OVER  | game finished, waits for restart or reset
module round_scoreboard #(
  parameter int BIRDS_PER_ROUND = 10,
  parameter int NUM_ROUNDS      = 16,
  parameter int PASS_HITS       = 5,
  parameter int HIT_POINTS      = 50,
  parameter int ESCAPE_PENALTY  = 10,
  parameter int SCORE_W         = 14,
  parameter int SCORE_MAX       = 9999
) (
  input logic              clk,
  input logic              reset_n,
  round_scoreboard_if.slave bus
);
  localparam int CNT_W  = $clog2(BIRDS_PER_ROUND + 1);
  localparam int RND_W  = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;
  localparam int BCNT_W = $clog2(SCORE_W + 1);
  localparam int SUM_W  = SCORE_W + 1;

  typedef enum logic [1:0] {PLAY, EVAL, OVER} state_t;

  state_t                     state, state_nxt;
  logic [BIRDS_PER_ROUND-1:0] map_q, map_nxt;
  logic [CNT_W-1:0]           hit_q, esc_q;
  logic [CNT_W:0]             slot;
  logic [RND_W-1:0]           round_q;
  logic [SCORE_W-1:0]         score_q, score_nxt;
  logic [SUM_W-1:0]           score_sum;
  logic                       score_chg;
  logic                       round_done_q, over_q, won_q;
  logic                       accept_hit, accept_esc, round_full, in_eval, eval_pass, last_round;
  logic [SCORE_W-1:0]         bin_sr;
  logic [15:0]                bcd_acc, bcd_q;
  logic [BCNT_W-1:0]          bit_cnt;
  logic                       bcd_valid_q;

  // One double-dabble step: add 3 to any digit >= 5, then shift in the next binary bit.
  function automatic logic [15:0] dd_step(input logic [15:0] acc, input logic b);
    logic [15:0] adj;
    adj = acc;
    for (int i = 0; i < 4; i++)
      if (adj[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
    return {adj[14:0], b};
  endfunction

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= PLAY;
    else          state <= state_nxt;
  end

  // Next-state logic; restart overrides everything.
  always_comb begin
    state_nxt = state;
    if (bus.restart) state_nxt = PLAY;
    else begin
      case (state)
        PLAY:    if (round_full) state_nxt = EVAL;
        EVAL:    state_nxt = (eval_pass && !last_round) ? PLAY : OVER;
        default: state_nxt = OVER;
      endcase
    end
  end

  // FSM decode: which event is accepted this cycle and how the round is judged.
  always_comb begin
    accept_esc = (state == PLAY) && bus.escape;
    accept_hit = (state == PLAY) && bus.hit && !bus.escape;
    in_eval    = (state == EVAL);
    eval_pass  = (hit_q >= CNT_W'(PASS_HITS));
    last_round = (round_q == RND_W'(NUM_ROUNDS - 1));
    slot       = {1'b0, hit_q} + {1'b0, esc_q};
    round_full = (accept_hit || accept_esc) &&
                 ((slot + (CNT_W+1)'(1)) == (CNT_W+1)'(BIRDS_PER_ROUND));
  end

  // Next bird map and saturating score for the accepted event.
  always_comb begin
    map_nxt   = map_q;
    for (int i = 0; i < BIRDS_PER_ROUND; i++)
      if (slot == (CNT_W+1)'(i)) map_nxt[i] = 1'b0;
    score_sum = {1'b0, score_q} + SUM_W'(HIT_POINTS);
    score_nxt = score_q;
    if (accept_esc)
      score_nxt = (score_q < SCORE_W'(ESCAPE_PENALTY)) ? '0 : score_q - SCORE_W'(ESCAPE_PENALTY);
    else if (accept_hit)
      score_nxt = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : score_sum[SCORE_W-1:0];
    score_chg = (score_nxt != score_q);
  end

  // Game-state registers: event counting, round advance and end-of-game flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      map_q <= '1; hit_q <= '0; esc_q <= '0; round_q <= '0; score_q <= '0;
      round_done_q <= 1'b0; over_q <= 1'b0; won_q <= 1'b0;
    end else if (bus.restart) begin
      map_q <= '1; hit_q <= '0; esc_q <= '0; round_q <= '0; score_q <= '0;
      round_done_q <= 1'b0; over_q <= 1'b0; won_q <= 1'b0;
    end else begin
      round_done_q <= (state_nxt == EVAL);
      score_q      <= score_nxt;
      if (accept_esc) esc_q <= esc_q + CNT_W'(1);
      if (accept_hit) begin
        hit_q <= hit_q + CNT_W'(1);
        map_q <= map_nxt;
      end
      if (in_eval) begin
        if (eval_pass && !last_round) begin
          round_q <= round_q + RND_W'(1);
          map_q   <= '1;
          hit_q   <= '0;
          esc_q   <= '0;
        end else begin
          over_q <= 1'b1;
          won_q  <= eval_pass;
        end
      end
    end
  end

  // Score-to-BCD: reload on every score change, shift one bit per cycle, publish when the bit counter expires.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bin_sr <= '0; bcd_acc <= '0; bit_cnt <= '0; bcd_q <= '0; bcd_valid_q <= 1'b1;
    end else if (bus.restart) begin
      bin_sr <= '0; bcd_acc <= '0; bit_cnt <= '0; bcd_q <= '0; bcd_valid_q <= 1'b1;
    end else if (score_chg) begin
      bin_sr      <= score_nxt;
      bcd_acc     <= '0;
      bit_cnt     <= BCNT_W'(SCORE_W);
      bcd_valid_q <= 1'b0;
    end else if (!bcd_valid_q) begin
      if (bit_cnt != '0) begin
        bcd_acc <= dd_step(bcd_acc, bin_sr[SCORE_W-1]);
        bin_sr  <= bin_sr << 1;
        bit_cnt <= bit_cnt - BCNT_W'(1);
      end else begin
        bcd_q       <= bcd_acc;
        bcd_valid_q <= 1'b1;
      end
    end
  end

  assign bus.bird_map   = map_q;
  assign bus.hit_count  = hit_q;
  assign bus.esc_count  = esc_q;
  assign bus.round      = round_q;
  assign bus.score      = score_q;
  assign bus.score_bcd  = bcd_q;
  assign bus.bcd_valid  = bcd_valid_q;
  assign bus.round_done = round_done_q;
  assign bus.game_over  = over_q;
  assign bus.game_won   = won_q;
endmodule
